hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 16-bit, 8-register MIPS core.
- Drives the enables of the PC, IF/ID and ID/EX registers and the bubble select (`ctrl_regs_sel`) of ID/EX.
- Computes the ALU operand forwarding selects latched by ID/EX.
- Tracks in-flight writers in a 3-entry scoreboard (EX, MEM, WB).
- Sequences load-use stalls, taken-branch flushes and memory-busy freezes, and keeps saturating stall/flush counters.

---
 rtl/hazard_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 16-bit,
// 8-register MIPS core.
//
// Tracks the destinations of the three in-flight instructions (EX, MEM, WB)
// and produces, combinationally from the current inputs, state and
// scoreboard:
//   - the PC / IF/ID / ID/EX register enables,
//   - the IF/ID flush and the ID/EX bubble select,
//   - the ALU operand forwarding selects latched by ID/EX.
// It also sequences load-use stalls, taken-branch flushes and memory-busy
// freezes, and keeps saturating stall/flush event counters.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   id_valid                 ID stage holds a real instruction
//   id_src1/2, id_use1/2     source register addresses and read flags
//   id_wr_en, id_write_addr  ID instruction writes the RF, destination
//   id_is_load               ID instruction is a memory load
//   branch_taken             branch in EX resolved taken
//   mem_busy                 data memory not ready, pipeline must freeze
//   pc_en, if_id_en,
//   id_ex_en                 stage register enables
//   if_id_flush              clear IF/ID
//   ctrl_regs_sel            load a bubble into ID/EX
//   alu_src_sel1/2           0 = RF, 1 = EX, 2 = MEM, 3 = WB producer
//   stall_cnt, flush_cnt     saturating event counters (CNT_W bits)

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_src1,
    input  logic [2:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_wr_en,
    input  logic [2:0]       id_write_addr,
    input  logic             id_is_load,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             if_id_flush,
    output logic             ctrl_regs_sel,
    output logic [1:0]       alu_src_sel1,
    output logic [1:0]       alu_src_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    logic [1:0]       state_q, state_d;

    // Scoreboard entries. Only the EX entry needs the load flag: load-use
    // is detected against EX alone, and once a load reaches MEM its data
    // is forwarded like any other producer.
    logic             sb_ex_wr_q, sb_ex_wr_d;
    logic [2:0]       sb_ex_addr_q, sb_ex_addr_d;
    logic             sb_ex_ld_q, sb_ex_ld_d;
    logic             sb_mem_wr_q, sb_mem_wr_d;
    logic [2:0]       sb_mem_addr_q, sb_mem_addr_d;
    logic             sb_wb_wr_q, sb_wb_wr_d;
    logic [2:0]       sb_wb_addr_q, sb_wb_addr_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic m1_ex, m1_mem, m1_wb;
    logic m2_ex, m2_mem, m2_wb;
    logic load_use;
    logic can_act;
    logic do_flush;
    logic do_lu;

    // r0 is hardwired zero, so an entry targeting it never forwards.
    function automatic logic src_match(input logic       use_i,
                                       input logic [2:0] src,
                                       input logic       wr,
                                       input logic [2:0] addr);
        return use_i && wr && (addr != 3'd0) && (addr == src);
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] fwd_sel(input logic m_ex,
                                           input logic m_mem,
                                           input logic m_wb);
        if (m_ex)  return 2'd1;
        if (m_mem) return 2'd2;
        if (m_wb)  return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    always_comb begin
        m1_ex  = src_match(id_use1, id_src1, sb_ex_wr_q,  sb_ex_addr_q);
        m1_mem = src_match(id_use1, id_src1, sb_mem_wr_q, sb_mem_addr_q);
        m1_wb  = src_match(id_use1, id_src1, sb_wb_wr_q,  sb_wb_addr_q);
        m2_ex  = src_match(id_use2, id_src2, sb_ex_wr_q,  sb_ex_addr_q);
        m2_mem = src_match(id_use2, id_src2, sb_mem_wr_q, sb_mem_addr_q);
        m2_wb  = src_match(id_use2, id_src2, sb_wb_wr_q,  sb_wb_addr_q);

        load_use = id_valid && sb_ex_ld_q && (m1_ex || m2_ex);

        // The cycle after a load-use bubble EX holds that bubble, so no
        // branch can resolve there and the stall must not retrigger.
        // A released freeze re-evaluates the held branch/load-use inputs.
        can_act  = (state_q != ST_STALL);
        do_flush = !mem_busy && can_act && branch_taken;
        do_lu    = !mem_busy && can_act && !branch_taken && load_use;

        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        ctrl_regs_sel = !id_valid;
        alu_src_sel1  = fwd_sel(m1_ex, m1_mem, m1_wb);
        alu_src_sel2  = fwd_sel(m2_ex, m2_mem, m2_wb);

        if (!rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b1;
            ctrl_regs_sel = 1'b1;
            alu_src_sel1  = 2'd0;
            alu_src_sel2  = 2'd0;
        end else if (mem_busy) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ctrl_regs_sel = 1'b0;
        end else if (do_flush) begin
            if_id_flush   = 1'b1;
            ctrl_regs_sel = 1'b1;
        end else if (do_lu) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ctrl_regs_sel = 1'b1;
            alu_src_sel1  = 2'd0;
            alu_src_sel2  = 2'd0;
        end

        if (mem_busy)   state_d = ST_FREEZE;
        else if (do_lu) state_d = ST_STALL;
        else            state_d = ST_RUN;

        sb_ex_wr_d    = sb_ex_wr_q;
        sb_ex_addr_d  = sb_ex_addr_q;
        sb_ex_ld_d    = sb_ex_ld_q;
        sb_mem_wr_d   = sb_mem_wr_q;
        sb_mem_addr_d = sb_mem_addr_q;
        sb_wb_wr_d    = sb_wb_wr_q;
        sb_wb_addr_d  = sb_wb_addr_q;
        if (id_ex_en) begin
            sb_wb_wr_d    = sb_mem_wr_q;
            sb_wb_addr_d  = sb_mem_addr_q;
            sb_mem_wr_d   = sb_ex_wr_q;
            sb_mem_addr_d = sb_ex_addr_q;
            // A bubble (flush, stall or empty ID) enters as a non-writer.
            sb_ex_wr_d    = id_valid && id_wr_en && !ctrl_regs_sel;
            sb_ex_addr_d  = id_write_addr;
            sb_ex_ld_d    = id_is_load;
        end

        stall_cnt_d = sat_inc(stall_cnt_q, mem_busy || do_lu);
        flush_cnt_d = sat_inc(flush_cnt_q, do_flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            sb_ex_wr_q    <= 1'b0;
            sb_ex_addr_q  <= 3'd0;
            sb_ex_ld_q    <= 1'b0;
            sb_mem_wr_q   <= 1'b0;
            sb_mem_addr_q <= 3'd0;
            sb_wb_wr_q    <= 1'b0;
            sb_wb_addr_q  <= 3'd0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sb_ex_wr_q    <= sb_ex_wr_d;
            sb_ex_addr_q  <= sb_ex_addr_d;
            sb_ex_ld_q    <= sb_ex_ld_d;
            sb_mem_wr_q   <= sb_mem_wr_d;
            sb_mem_addr_q <= sb_mem_addr_d;
            sb_wb_wr_q    <= sb_wb_wr_d;
            sb_wb_addr_q  <= sb_wb_addr_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
